// File: rtl/smi_axi_read_burst_splitter_if.sv
// Bus bundle for the SMI read-request to AXI AR burst splitter.
// Groups the SMI request flit port, the AXI read-address channel, the
// ID-return port and the parameter-cache record port.
// The "master" modport is the splitter's view; "slave" is the environment's view.
interface smi_axi_read_burst_splitter_if #(
    parameter int DataIndexSize = 4,
    parameter int AxiIdWidth    = 4
);
    localparam int DataWidth = 8 << DataIndexSize;

    // SMI request flits
    logic                  smiReqReady;
    logic [7:0]            smiReqEofc;
    logic [DataWidth-1:0]  smiReqData;
    logic                  smiReqStop;

    // AXI read-address channel
    logic                  axiARValid;
    logic                  axiARReady;
    logic [AxiIdWidth-1:0] axiARId;
    logic [63:0]           axiARAddr;
    logic [7:0]            axiARLen;
    logic [2:0]            axiARSize;

    // ID return from the response side
    logic                  idFreeValid;
    logic [AxiIdWidth-1:0] idFree;

    // Parameter-cache record
    logic                  pCacheWrite;
    logic [AxiIdWidth-1:0] pCacheId;
    logic [15:0]           pCacheTag;
    logic [7:0]            pCacheOffset;
    logic [15:0]           pCacheCount;
    logic                  pCacheLast;

    modport master (
        input  smiReqReady, smiReqEofc, smiReqData,
        output smiReqStop,
        output axiARValid, axiARId, axiARAddr, axiARLen, axiARSize,
        input  axiARReady,
        input  idFreeValid, idFree,
        output pCacheWrite, pCacheId, pCacheTag, pCacheOffset, pCacheCount, pCacheLast
    );

    modport slave (
        output smiReqReady, smiReqEofc, smiReqData,
        input  smiReqStop,
        input  axiARValid, axiARId, axiARAddr, axiARLen, axiARSize,
        output axiARReady,
        output idFreeValid, idFree,
        input  pCacheWrite, pCacheId, pCacheTag, pCacheOffset, pCacheCount, pCacheLast
    );
endinterface

// File: rtl/smi_axi_read_burst_splitter.sv
// SMI read-request to AXI read-address dispatcher.
// Takes a header flit (tag, 64-bit address, byte length), allocates AXI IDs
// from a recycled free-ID FIFO and issues AR bursts that never cross a 4KB
// boundary nor exceed MaxBurstLen beats, writing one parameter-cache record
// per burst at the AR handshake.
// Optional feature: define SMI_AXI_RD_STATS_EN to add the statsRequests and
// statsBursts counters/ports.
//
// Handshakes: an SMI flit transfers on a rising edge where smiReqReady=1 and
// smiReqStop=0; an AR transfers on a rising edge where axiARValid=1 and
// axiARReady=1, and axiARValid/payload stay stable until then. idFreeValid
// is a one-cycle push with no backpressure.
module smi_axi_read_burst_splitter #(
    parameter int DataIndexSize = 4,
    parameter int AxiIdWidth    = 4,
    parameter int MaxBurstLen   = 256
) (
    input  logic                          clk,
    input  logic                          rstn,
    smi_axi_read_burst_splitter_if.master bus,
`ifdef SMI_AXI_RD_STATS_EN
    output logic [31:0]                   statsRequests,
    output logic [31:0]                   statsBursts,
`endif
    output logic [2:0]                    dbgState
);
    localparam int          DataWidth     = 8 << DataIndexSize;
    localparam int          MaxIds        = 1 << AxiIdWidth;
    localparam logic [16:0] MaxBurstBytes = 17'(MaxBurstLen << DataIndexSize);

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        CALC  = 3'd2,
        ISSUE = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t state, stateNext;

    // Free-ID FIFO
    logic [AxiIdWidth-1:0] fifoMem [MaxIds];
    logic [AxiIdWidth-1:0] wrPtr, rdPtr, initCnt, fifoPushId;
    logic [AxiIdWidth:0]   fifoCount;
    logic                  fifoPush, fifoPop, fifoEmpty;

    // Request context
    logic [15:0] tagReg;
    logic [63:0] addrReg;
    logic [16:0] remReg;
    logic        frameEnded;

    // AR / record registers
    logic                  arValidReg;
    logic [AxiIdWidth-1:0] arIdReg;
    logic [63:0]           arAddrReg;
    logic [7:0]            arLenReg;
    logic [15:0]           pcTagReg;
    logic [7:0]            pcOffsetReg;
    logic [15:0]           pcCountReg;
    logic                  pcLastReg;

    // Burst sizing
    logic [16:0] offset17, toBoundary, burstRoom, chunk, lenSum;
    logic [7:0]  calcLen;

    logic hdrAccept, arHandshake, stopComb;
    logic unusedHdrBits;

    assign fifoEmpty   = (fifoCount == '0);
    assign fifoPop     = (state == CALC) && !fifoEmpty;
    assign fifoPush    = (state == INIT) || bus.idFreeValid;
    assign fifoPushId  = (state == INIT) ? initCnt : bus.idFree;
    assign hdrAccept   = (state == IDLE) && bus.smiReqReady;
    assign arHandshake = arValidReg && bus.axiARReady;

    // Header bits outside tag/address/length carry nothing for this block.
    assign unusedHdrBits = ^{bus.smiReqData[DataWidth-1:112], bus.smiReqData[15:0]};

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= INIT;
        else       state <= stateNext;
    end

    // Next-state logic and SMI backpressure.
    always_comb begin
        stateNext = state;
        stopComb  = 1'b1;
        case (state)
            INIT: begin
                if (initCnt == AxiIdWidth'(MaxIds - 1)) stateNext = IDLE;
            end
            IDLE: begin
                stopComb = 1'b0;
                if (bus.smiReqReady) stateNext = CALC;
            end
            CALC: begin
                if (!fifoEmpty) stateNext = ISSUE;
            end
            ISSUE: begin
                if (arHandshake) begin
                    if (!pcLastReg)      stateNext = CALC;
                    else if (frameEnded) stateNext = IDLE;
                    else                 stateNext = DRAIN;
                end
            end
            DRAIN: begin
                stopComb = 1'b0;
                if (bus.smiReqReady && (bus.smiReqEofc != 8'd0)) stateNext = IDLE;
            end
            default: stateNext = INIT;
        endcase
    end

    // Free-ID FIFO storage; contents need no reset since INIT refills it.
    always_ff @(posedge clk) begin
        if (fifoPush) fifoMem[wrPtr] <= fifoPushId;
    end

    // Free-ID FIFO pointers, occupancy and the INIT fill counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            initCnt   <= '0;
        end else begin
            if (state == INIT) initCnt <= initCnt + 1'b1;
            if (fifoPush) wrPtr <= wrPtr + 1'b1;
            if (fifoPop)  rdPtr <= rdPtr + 1'b1;
            if (fifoPush && !fifoPop)      fifoCount <= fifoCount + 1'b1;
            else if (!fifoPush && fifoPop) fifoCount <= fifoCount - 1'b1;
        end
    end

    // Burst size: limited by remaining bytes, the 4KB page and the beat cap.
    always_comb begin
        offset17   = 17'(addrReg[DataIndexSize-1:0]);
        toBoundary = 17'd4096 - {5'd0, addrReg[11:0]};
        burstRoom  = MaxBurstBytes - offset17;
        chunk      = remReg;
        if (toBoundary < chunk) chunk = toBoundary;
        if (burstRoom < chunk)  chunk = burstRoom;
        lenSum     = offset17 + chunk - 17'd1;
        // A zero-length request still goes out as a single beat.
        calcLen    = (remReg == 17'd0) ? 8'd0 : 8'(lenSum >> DataIndexSize);
    end

    // Request context: latched from the header, advanced per accepted burst.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tagReg     <= '0;
            addrReg    <= '0;
            remReg     <= '0;
            frameEnded <= 1'b0;
        end else if (hdrAccept) begin
            tagReg     <= bus.smiReqData[31:16];
            addrReg    <= bus.smiReqData[95:32];
            remReg     <= {1'b0, bus.smiReqData[111:96]};
            frameEnded <= (bus.smiReqEofc != 8'd0);
        end else if (arHandshake) begin
            addrReg <= addrReg + 64'(pcCountReg);
            remReg  <= remReg - {1'b0, pcCountReg};
        end
    end

    // AR payload and cache record, loaded when an ID is popped in CALC.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            arValidReg  <= 1'b0;
            arIdReg     <= '0;
            arAddrReg   <= '0;
            arLenReg    <= '0;
            pcTagReg    <= '0;
            pcOffsetReg <= '0;
            pcCountReg  <= '0;
            pcLastReg   <= 1'b0;
        end else if (fifoPop) begin
            arValidReg  <= 1'b1;
            arIdReg     <= fifoMem[rdPtr];
            arAddrReg   <= addrReg;
            arLenReg    <= calcLen;
            pcTagReg    <= tagReg;
            pcOffsetReg <= offset17[7:0];
            pcCountReg  <= chunk[15:0];
            pcLastReg   <= (remReg == chunk);
        end else if (arHandshake) begin
            arValidReg <= 1'b0;
        end
    end

`ifdef SMI_AXI_RD_STATS_EN
    // Free-running request and burst counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            statsRequests <= '0;
            statsBursts   <= '0;
        end else begin
            if (hdrAccept)   statsRequests <= statsRequests + 32'd1;
            if (arHandshake) statsBursts   <= statsBursts + 32'd1;
        end
    end
`endif

    // Combinational outputs are forced low while reset is held.
    always_comb begin
        bus.smiReqStop = rstn && stopComb;
        bus.axiARSize  = rstn ? 3'(DataIndexSize) : 3'd0;
    end

    assign bus.axiARValid   = arValidReg;
    assign bus.axiARId      = arIdReg;
    assign bus.axiARAddr    = arAddrReg;
    assign bus.axiARLen     = arLenReg;
    assign bus.pCacheWrite  = arHandshake;
    assign bus.pCacheId     = arIdReg;
    assign bus.pCacheTag    = pcTagReg;
    assign bus.pCacheOffset = pcOffsetReg;
    assign bus.pCacheCount  = pcCountReg;
    assign bus.pCacheLast   = pcLastReg;
    assign dbgState         = state;
endmodule

// File: tb/tb_smi_axi_read_burst_splitter.sv
// Bench for smi_axi_read_burst_splitter (default parameters).
// Expected AR/cache records are pushed into expQ before each request;
// a monitor pops and compares them at every AR handshake.
module tb_smi_axi_read_burst_splitter;
    localparam int DataIndexSize = 4;
    localparam int AxiIdWidth    = 4;
    localparam int MaxBurstLen   = 256;
    localparam int DataWidth     = 8 << DataIndexSize;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [15:0] tag;
        logic [7:0]  offset;
        logic [15:0] count;
        logic        last;
    } arRec_t;
    localparam int RecW = $bits(arRec_t);

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    smi_axi_read_burst_splitter_if #(.DataIndexSize(DataIndexSize), .AxiIdWidth(AxiIdWidth)) bus ();
    logic [2:0] dbgState;
`ifdef SMI_AXI_RD_STATS_EN
    logic [31:0] statsRequests, statsBursts;
`endif

    smi_axi_read_burst_splitter #(
        .DataIndexSize(DataIndexSize),
        .AxiIdWidth   (AxiIdWidth),
        .MaxBurstLen  (MaxBurstLen)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .bus          (bus.master),
`ifdef SMI_AXI_RD_STATS_EN
        .statsRequests(statsRequests),
        .statsBursts  (statsBursts),
`endif
        .dbgState     (dbgState)
    );

    logic [159:0] allOut;
    assign allOut = 160'({bus.smiReqStop, bus.axiARValid, bus.axiARId, bus.axiARAddr, bus.axiARLen,
                          bus.axiARSize, bus.pCacheWrite, bus.pCacheId, bus.pCacheTag, bus.pCacheOffset,
                          bus.pCacheCount, bus.pCacheLast, dbgState});

    // ---------------- scoreboard ----------------
    logic [RecW-1:0] expQ[$];
    int checks = 0;
    int errors = 0;

    task automatic checkVal(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Monitor: strobe/handshake consistency every cycle, record compare per AR.
    logic            monHs;
    logic [RecW-1:0] monExp, monAct;
    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                monHs = bus.axiARValid && bus.axiARReady;
                checkVal("pcache_strobe", 160'(bus.pCacheWrite), 160'(monHs));
                if (monHs) begin
                    monAct = {bus.axiARId, bus.axiARAddr, bus.axiARLen, bus.pCacheTag,
                              bus.pCacheOffset, bus.pCacheCount, bus.pCacheLast};
                    if (expQ.size() == 0) begin
                        checkVal("unexpected_ar", 160'(monAct), 160'(0));
                    end else begin
                        monExp = expQ.pop_front();
                        checkVal("ar_record", 160'(monAct), 160'(monExp));
                        checkVal("pcache_id", 160'(bus.pCacheId), 160'(monExp[RecW-1 -: 4]));
                        checkVal("ar_size", 160'(bus.axiARSize), 160'(4));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [DataWidth-1:0] header(input logic [15:0] tag, input logic [63:0] addr,
                                                    input logic [15:0] len);
        logic [DataWidth-1:0] d;
        d          = '0;
        d[15:0]    = 16'hA5A5;
        d[31:16]   = tag;
        d[95:32]   = addr;
        d[111:96]  = len;
        return d;
    endfunction

    task automatic expectAr(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [15:0] tag, input logic [7:0] off, input logic [15:0] cnt,
                            input logic last);
        arRec_t r;
        r = '{id: id, addr: addr, len: len, tag: tag, offset: off, count: cnt, last: last};
        expQ.push_back(RecW'(r));
    endtask

    task automatic sendFlit(input logic [DataWidth-1:0] d, input logic [7:0] eofc);
        int waitCnt;
        waitCnt = 0;
        bus.smiReqReady = 1'b1;
        bus.smiReqData  = d;
        bus.smiReqEofc  = eofc;
        forever begin
            @(negedge clk);
            if (!bus.smiReqStop) break;
            waitCnt++;
            if (waitCnt > 300) begin
                failNow("smi_flit_accept");
                break;
            end
        end
        @(posedge clk); #1;
        bus.smiReqReady = 1'b0;
        bus.smiReqEofc  = 8'd0;
    endtask

    task automatic waitDrain(input string name);
        int waitCnt;
        waitCnt = 0;
        while (expQ.size() != 0) begin
            @(negedge clk);
            waitCnt++;
            if (waitCnt > 500) begin
                failNow(name);
                expQ.delete();
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic waitValid(input string name);
        int waitCnt;
        waitCnt = 0;
        forever begin
            @(negedge clk);
            if (bus.axiARValid) break;
            waitCnt++;
            if (waitCnt > 50) begin
                failNow(name);
                break;
            end
        end
    endtask

    task automatic freeId(input logic [3:0] id);
        @(posedge clk); #1;
        bus.idFreeValid = 1'b1;
        bus.idFree      = id;
        @(posedge clk); #1;
        bus.idFreeValid = 1'b0;
    endtask

    // rstn has just been released right after a rising edge.
    task automatic checkInit();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checkVal("init_stop", 160'(bus.smiReqStop), 160'(1));
        end
        @(negedge clk);
        checkVal("init_done_stop", 160'(bus.smiReqStop), 160'(0));
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.smiReqReady = 1'b0;
        bus.smiReqEofc  = 8'd0;
        bus.smiReqData  = '0;
        bus.axiARReady  = 1'b1;
        bus.idFreeValid = 1'b0;
        bus.idFree      = '0;

        repeat (3) @(posedge clk);
        #1;
        checkVal("reset_outputs", allOut, 160'(0));
        rstn = 1'b1;
        checkInit();

        // Aligned single burst, with first-AR latency.
        expectAr(4'd0, 64'h1000, 8'd3, 16'h0011, 8'd0, 16'd64, 1'b1);
        sendFlit(header(16'h0011, 64'h1000, 16'd64), 8'h01);
        @(negedge clk);
        checkVal("calc_no_valid", 160'(bus.axiARValid), 160'(0));
        checkVal("calc_stop", 160'(bus.smiReqStop), 160'(1));
        @(negedge clk);
        checkVal("first_ar_latency", 160'(bus.axiARValid), 160'(1));
        waitDrain("t1_drain");

        // 4KB crossing, three-flit frame drained afterwards.
        expectAr(4'd1, 64'h0FF8, 8'd0, 16'h0022, 8'd8, 16'd8, 1'b0);
        expectAr(4'd2, 64'h1000, 8'd1, 16'h0022, 8'd0, 16'd24, 1'b1);
        sendFlit(header(16'h0022, 64'h0FF8, 16'd32), 8'h00);
        sendFlit(128'h5, 8'h00);
        sendFlit(128'h6, 8'h80);
        waitDrain("t2_drain");

        // 16KB split into four maximal bursts.
        for (int k = 0; k < 4; k++)
            expectAr(4'(3 + k), 64'(k * 4096), 8'd255, 16'h0033, 8'd0, 16'd4096, (k == 3));
        sendFlit(header(16'h0033, 64'h0, 16'd16384), 8'h01);
        waitDrain("t3_drain");

        // Unaligned start within a word.
        expectAr(4'd7, 64'h1234, 8'd6, 16'h0044, 8'd4, 16'd100, 1'b1);
        sendFlit(header(16'h0044, 64'h1234, 16'd100), 8'h01);
        waitDrain("t4_drain");

        // Zero-length request.
        expectAr(4'd8, 64'h0050, 8'd0, 16'h0055, 8'd0, 16'd0, 1'b1);
        sendFlit(header(16'h0055, 64'h0050, 16'd0), 8'h01);
        waitDrain("t5_drain");

        // AR backpressure for 10 cycles.
        bus.axiARReady = 1'b0;
        expectAr(4'd9, 64'h2000, 8'd0, 16'h0066, 8'd0, 16'd16, 1'b1);
        sendFlit(header(16'h0066, 64'h2000, 16'd16), 8'h01);
        waitValid("t6_valid");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkVal("hold_valid", 160'(bus.axiARValid), 160'(1));
            checkVal("hold_payload",
                     160'({bus.axiARId, bus.axiARAddr, bus.axiARLen, bus.pCacheTag,
                           bus.pCacheOffset, bus.pCacheCount, bus.pCacheLast}),
                     160'({4'd9, 64'h2000, 8'd0, 16'h0066, 8'd0, 16'd16, 1'b1}));
        end
        @(posedge clk); #1;
        bus.axiARReady = 1'b1;
        waitDrain("t6_drain");

        // Offset start hitting both the page and the beat cap.
        expectAr(4'd10, 64'h3008, 8'd255, 16'h0077, 8'd8, 16'd4088, 1'b0);
        expectAr(4'd11, 64'h4000, 8'd244, 16'h0077, 8'd0, 16'd3912, 1'b1);
        sendFlit(header(16'h0077, 64'h3008, 16'd8000), 8'h01);
        waitDrain("t7_drain");

        // Use up the remaining IDs.
        for (int k = 0; k < 4; k++) begin
            expectAr(4'(12 + k), 64'h10000 + 64'(k * 64), 8'd1, 16'h0070 + 16'(k), 8'd0, 16'd32, 1'b1);
            sendFlit(header(16'h0070 + 16'(k), 64'h10000 + 64'(k * 64), 16'd32), 8'h01);
        end
        waitDrain("t8_drain");

        // Empty pool: header accepted, then stall until an ID comes back.
        sendFlit(header(16'h0099, 64'h5000, 16'd16), 8'h01);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkVal("stall_no_valid", 160'(bus.axiARValid), 160'(0));
            checkVal("stall_stop", 160'(bus.smiReqStop), 160'(1));
        end
        expectAr(4'd2, 64'h5000, 8'd0, 16'h0099, 8'd0, 16'd16, 1'b1);
        freeId(4'd2);
        waitDrain("t9_drain");

        // Reset in the middle of a split.
        bus.axiARReady = 1'b0;
        freeId(4'd7);
        sendFlit(header(16'h00AA, 64'h0, 16'd8192), 8'h01);
        waitValid("t10_valid");
        checkVal("pre_reset_id", 160'(bus.axiARId), 160'(7));
        #2;
        rstn = 1'b0;
        #1;
        checkVal("reset_async_outputs", allOut, 160'(0));
        @(posedge clk); #1;
        bus.axiARReady = 1'b1;
        rstn = 1'b1;
        checkInit();

        // Free pool is full again, in order.
        for (int k = 0; k < 16; k++) begin
            expectAr(4'(k), 64'h20000 + 64'(k * 256), 8'd0, 16'h00B0 + 16'(k), 8'd0, 16'd16, 1'b1);
            sendFlit(header(16'h00B0 + 16'(k), 64'h20000 + 64'(k * 256), 16'd16), 8'h01);
        end
        waitDrain("t11_drain");

`ifdef SMI_AXI_RD_STATS_EN
        checkVal("stats_requests", 160'(statsRequests), 160'(16));
        checkVal("stats_bursts", 160'(statsBursts), 160'(16));
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
